// File: rtl/reset_controller.sv
// reset_controller: merges power-up/block reset, a debounced push-button and
// the system trap flag into one registered power_on_reset. Resets are
// stretched by HOLD cycles and a trap halts the system for TRAP_DELAY cycles
// before an automatic restart.
`timescale 1ns/1ps

module reset_controller #(
    parameter int DEBOUNCE       = 16,
    parameter int HOLD           = 32,
    parameter int TRAP_DELAY     = 1024,
    parameter int TRAP_AUTORESET = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       trap,
    output logic       power_on_reset,
    output logic [1:0] reset_cause,
    output logic [7:0] trap_count
);

    localparam int CNT_MAX = (HOLD > TRAP_DELAY) ? HOLD : TRAP_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int DB_W    = $clog2(DEBOUNCE) + 1;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PRESSED = 2'd2;
    localparam logic [1:0] ST_TRAPPED = 2'd3;

    localparam logic [1:0] CAUSE_POWER  = 2'd0;
    localparam logic [1:0] CAUSE_BUTTON = 2'd1;
    localparam logic [1:0] CAUSE_TRAP   = 2'd2;

    logic            btn_meta;
    logic            btn_sync;
    logic            btn_stable;
    logic [DB_W-1:0] cnt_db;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       cause_nx;
    logic [7:0]       trap_count_nx;

    // Synchronise the active-low button and debounce it into btn_stable.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours (the 2-FF chain relies on it).
        if (reset) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            btn_stable <= 1'b0;
            cnt_db     <= '0;
        end else begin
            btn_meta <= ~btn_n;
            btn_sync <= btn_meta;
            if (btn_sync == btn_stable) begin
                cnt_db <= '0;
            end else if (cnt_db == DB_W'(DEBOUNCE - 1)) begin
                btn_stable <= btn_sync;
                cnt_db     <= '0;
            end else begin
                cnt_db <= cnt_db + DB_W'(1);
            end
        end
    end

    // Next-state logic for the reset sequencer, including cause and trap count.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nx      = state;
        cnt_nx        = cnt;
        cause_nx      = reset_cause;
        trap_count_nx = trap_count;
        case (state)
            ST_HOLD: begin
                if (cnt == CNT_W'(HOLD - 1)) begin
                    cnt_nx   = '0;
                    state_nx = btn_stable ? ST_PRESSED : ST_RUN;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // The button wins over a trap seen in the same cycle.
                if (btn_stable) begin
                    state_nx = ST_PRESSED;
                    cnt_nx   = '0;
                    cause_nx = CAUSE_BUTTON;
                end else if (trap && (TRAP_AUTORESET != 0)) begin
                    state_nx = ST_TRAPPED;
                    cnt_nx   = '0;
                    cause_nx = CAUSE_TRAP;
                    if (trap_count != 8'hFF) trap_count_nx = trap_count + 8'd1;
                end
            end
            ST_PRESSED: begin
                if (!btn_stable) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = '0;
                end
            end
            ST_TRAPPED: begin
                // A debounced press cuts the halt short, even on the expiry cycle.
                if (btn_stable) begin
                    state_nx = ST_PRESSED;
                    cnt_nx   = '0;
                    cause_nx = CAUSE_BUTTON;
                end else if (cnt == CNT_W'(TRAP_DELAY - 1)) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_HOLD;
                cnt_nx   = '0;
            end
        endcase
    end

    // Register state and outputs; por is decoded from the next state so it
    // lines up with the state register and has no input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_HOLD;
            cnt            <= '0;
            power_on_reset <= 1'b1;
            reset_cause    <= CAUSE_POWER;
            trap_count     <= 8'd0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            power_on_reset <= (state_nx == ST_HOLD) || (state_nx == ST_PRESSED);
            reset_cause    <= cause_nx;
            trap_count     <= trap_count_nx;
        end
    end

endmodule

// File: tb/tb_reset_controller.sv
// Bench for reset_controller: expected output values are queued per clock edge
// as stimulus is applied, and a monitor pops and compares them each cycle.
`timescale 1ns/1ps

module tb_reset_controller;

    typedef struct {
        int         due;
        int         inst;
        logic       por;
        logic [1:0] cause;
        logic [7:0] tc;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_n, trap;
    logic       btn_n_f, trap_f;
    logic       por_m, por_s, por_n;
    logic [1:0] cause_m, cause_s, cause_n;
    logic [7:0] tc_m, tc_s, tc_n;

    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    exp_t x;
    logic       got_por;
    logic [1:0] got_cause;
    logic [7:0] got_tc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Main instance with default parameters.
    reset_controller u_main (
        .clk(clk), .reset(reset), .btn_n(btn_n), .trap(trap),
        .power_on_reset(por_m), .reset_cause(cause_m), .trap_count(tc_m)
    );

    // Short-timing instance used for trap_count saturation.
    reset_controller #(.DEBOUNCE(2), .HOLD(1), .TRAP_DELAY(1), .TRAP_AUTORESET(1)) u_sat (
        .clk(clk), .reset(reset), .btn_n(btn_n_f), .trap(trap_f),
        .power_on_reset(por_s), .reset_cause(cause_s), .trap_count(tc_s)
    );

    // Same timing with auto-reset disabled: traps must be ignored.
    reset_controller #(.DEBOUNCE(2), .HOLD(1), .TRAP_DELAY(1), .TRAP_AUTORESET(0)) u_noar (
        .clk(clk), .reset(reset), .btn_n(btn_n_f), .trap(trap_f),
        .power_on_reset(por_n), .reset_cause(cause_n), .trap_count(tc_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc_cnt);
        else n_pass++;
    endtask

    task automatic push(input string tag, input int inst, input int due,
                        input logic por, input logic [1:0] cause, input logic [7:0] tc);
        exp_t e;
        e.due = due; e.inst = inst; e.por = por; e.cause = cause; e.tc = tc; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int e);
        while (cyc_cnt < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare every expectation due at the most recent edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
            x = sb.pop_front();
            case (x.inst)
                0:       begin got_por = por_m; got_cause = cause_m; got_tc = tc_m; end
                1:       begin got_por = por_s; got_cause = cause_s; got_tc = tc_s; end
                default: begin got_por = por_n; got_cause = cause_n; got_tc = tc_n; end
            endcase
            check({x.tag, "_por"}, 32'(got_por), 32'(x.por));
            check({x.tag, "_cause"}, 32'(got_cause), 32'(x.cause));
            check({x.tag, "_tc"}, 32'(got_tc), 32'(x.tc));
        end
    end

    initial begin
        int e0;
        reset = 1'b1; btn_n = 1'b1; trap = 1'b0; btn_n_f = 1'b1; trap_f = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: one-cycle reset -> por high for exactly HOLD=32 edges.
        e0 = cyc_cnt;
        for (int e = e0; e <= e0 + 40; e++) push("t1_hold", 0, e, (e - e0) < 32, 2'd0, 8'd0);
        wait_to(e0 + 40);

        // 2: button low for 15 cycles is one short of DEBOUNCE -> ignored.
        e0 = cyc_cnt;
        btn_n = 1'b0;
        for (int e = e0 + 1; e <= e0 + 40; e++) push("t2_short", 0, e, 1'b0, 2'd0, 8'd0);
        wait_to(e0 + 15); btn_n = 1'b1;
        wait_to(e0 + 40);

        // 3: long press; por rises 18 edges after the first sync capture,
        // drops 32 cycles after btn_stable falls.
        e0 = cyc_cnt;
        btn_n = 1'b0;
        for (int e = e0 + 1; e <= e0 + 160; e++)
            push("t3_press", 0, e, (e >= e0 + 19) && (e <= e0 + 150), (e >= e0 + 19) ? 2'd1 : 2'd0, 8'd0);
        wait_to(e0 + 100); btn_n = 1'b1;
        wait_to(e0 + 160);

        // 4: one-cycle trap -> 1024 halted cycles, then 32 of por.
        e0 = cyc_cnt;
        trap = 1'b1;
        for (int e = e0 + 1; e <= e0 + 1060; e++)
            push("t4_trap", 0, e, (e >= e0 + 1025) && (e <= e0 + 1056), 2'd2, 8'd1);
        wait_to(e0 + 1); trap = 1'b0;
        wait_to(e0 + 1060);

        // 5a: trap arrives in the cycle btn_stable rises -> button wins.
        e0 = cyc_cnt;
        btn_n = 1'b0;
        for (int e = e0 + 1; e <= e0 + 90; e++)
            push("t5_same", 0, e, (e >= e0 + 19) && (e <= e0 + 80), (e >= e0 + 19) ? 2'd1 : 2'd2, 8'd1);
        wait_to(e0 + 18); trap = 1'b1;
        wait_to(e0 + 19); trap = 1'b0;
        wait_to(e0 + 30); btn_n = 1'b1;
        wait_to(e0 + 90);

        // 5b: button debounced during TRAPPED -> PRESSED, cause=button.
        e0 = cyc_cnt;
        trap = 1'b1;
        for (int e = e0 + 1; e <= e0 + 260; e++)
            push("t5_trapbtn", 0, e, (e >= e0 + 119) && (e <= e0 + 250), (e >= e0 + 119) ? 2'd1 : 2'd2, 8'd2);
        wait_to(e0 + 1); trap = 1'b0;
        wait_to(e0 + 100); btn_n = 1'b0;
        wait_to(e0 + 200); btn_n = 1'b1;
        wait_to(e0 + 260);

        // 6: block reset at cnt=500 in TRAPPED clears everything, HOLD restarts.
        e0 = cyc_cnt;
        trap = 1'b1;
        for (int e = e0 + 1; e <= e0 + 501; e++) push("t6_pre", 0, e, 1'b0, 2'd2, 8'd3);
        for (int e = e0 + 502; e <= e0 + 540; e++) push("t6_rst", 0, e, e <= e0 + 533, 2'd0, 8'd0);
        wait_to(e0 + 1); trap = 1'b0;
        wait_to(e0 + 501); reset = 1'b1;
        wait_to(e0 + 502); reset = 1'b0;
        wait_to(e0 + 540);

        // 4b: 256 traps saturate trap_count at 255; auto-reset off ignores them.
        for (int i = 1; i <= 256; i++) begin
            logic [7:0] exp_tc;
            exp_tc = (i < 255) ? 8'(i) : 8'd255;
            e0 = cyc_cnt;
            trap_f = 1'b1;
            push("t4b_sat_trap", 1, e0 + 1, 1'b0, 2'd2, exp_tc);
            push("t4b_noar", 2, e0 + 1, 1'b0, 2'd0, 8'd0);
            push("t4b_sat_hold", 1, e0 + 2, 1'b1, 2'd2, exp_tc);
            wait_to(e0 + 1); trap_f = 1'b0;
            wait_to(e0 + 4);
        end

        wait_to(cyc_cnt + 2);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
